// File: rtl/match_reporter.sv
// Match reporter: output-table lookup on each scanned state, two-stage pipeline into a match FIFO.
// Optional MATCH_CNT counter enabled by defining MATCH_REPORTER_CNT_EN.
module match_reporter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned POS_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [7:0]       NOW_STATE,
  input  logic             OUT_WE,
  input  logic [7:0]       OUT_WADDR,
  input  logic [4:0]       OUT_WDATA,
  output logic             MATCH_VALID,
  input  logic             MATCH_READY,
  output logic [3:0]       MATCH_PID,
  output logic [POS_W-1:0] MATCH_POS,
  output logic             OVERFLOW,
  output logic [15:0]      MATCH_CNT
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = POS_W + 4;

  logic [4:0]       r_table [256];

  logic             r_s1_valid;
  logic [4:0]       r_s1_entry;
  logic [POS_W-1:0] r_s1_pos;
  logic [POS_W-1:0] r_pos;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_drop;
  logic [AW:0]      w_count;
  logic [EW-1:0]    w_head;

  // Table writes are not gated by RST; a same-cycle read sees the old entry.
  always_ff @(posedge CLK) begin
    if (OUT_WE) begin
      r_table[OUT_WADDR] <= OUT_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_pos      <= '0;
    end else begin
      r_s1_valid <= EN;
      if (EN) begin
        r_s1_entry <= r_table[NOW_STATE];
        r_s1_pos   <= r_pos;
        r_pos      <= r_pos + POS_W'(1);
      end
    end
  end

  always_comb begin
    w_push   = r_s1_valid & r_s1_entry[4];
    w_count  = r_wr_ptr - r_rd_ptr;
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
    w_pop    = ~w_empty & MATCH_READY;
    // A full FIFO still accepts when the head leaves in the same cycle.
    w_accept = w_push & (~w_full | w_pop);
    w_drop   = w_push & w_full & ~w_pop;
    w_head   = r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_s1_entry[3:0], r_s1_pos};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head fields are forced to zero while empty so reset shows PID/POS of 0.
  assign MATCH_VALID = ~w_empty;
  assign MATCH_PID   = w_empty ? 4'd0 : w_head[EW-1:POS_W];
  assign MATCH_POS   = w_empty ? '0 : w_head[POS_W-1:0];
  assign OVERFLOW    = r_overflow;

`ifdef MATCH_REPORTER_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_push && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign MATCH_CNT = r_cnt;
`else
  assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_match_reporter.sv
// Directed self-checking bench for match_reporter (default build and a POS_W=4 instance).
module tb_match_reporter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [7:0]  NOW_STATE;
  logic        OUT_WE;
  logic [7:0]  OUT_WADDR;
  logic [4:0]  OUT_WDATA;
  logic        MATCH_READY;

  logic        mv, ovf, mv4, ovf4;
  logic [3:0]  pid, pid4;
  logic [15:0] pos;
  logic [3:0]  pos4;
  logic [15:0] cnt, cnt4;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MATCH_REPORTER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 CLK = ~CLK;

  match_reporter #(.FIFO_DEPTH(8), .POS_W(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .NOW_STATE(NOW_STATE),
    .OUT_WE(OUT_WE), .OUT_WADDR(OUT_WADDR), .OUT_WDATA(OUT_WDATA),
    .MATCH_VALID(mv), .MATCH_READY(MATCH_READY), .MATCH_PID(pid),
    .MATCH_POS(pos), .OVERFLOW(ovf), .MATCH_CNT(cnt)
  );

  match_reporter #(.FIFO_DEPTH(8), .POS_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .EN(EN), .NOW_STATE(NOW_STATE),
    .OUT_WE(OUT_WE), .OUT_WADDR(OUT_WADDR), .OUT_WDATA(OUT_WDATA),
    .MATCH_VALID(mv4), .MATCH_READY(MATCH_READY), .MATCH_PID(pid4),
    .MATCH_POS(pos4), .OVERFLOW(ovf4), .MATCH_CNT(cnt4)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; MATCH_READY = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic write_tab(input logic [7:0] a, input logic [4:0] d);
    OUT_WE = 1'b1; OUT_WADDR = a; OUT_WDATA = d;
    step();
    OUT_WE = 1'b0;
  endtask

  task automatic feed(input logic [7:0] s);
    EN = 1'b1; NOW_STATE = s;
    step();
    EN = 1'b0;
  endtask

  task automatic pop();
    MATCH_READY = 1'b1;
    step();
    MATCH_READY = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", mv); end
    n_cmp++; if (pid !== 4'd0) begin n_err++; $display("FAIL reset_pid: got %0d want 0", pid); end
    n_cmp++; if (pos !== 16'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    write_tab(8'd5, 5'h13);
    feed(8'd0); feed(8'd0); feed(8'd5);
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", mv); end
    step();
    n_cmp++; if (mv !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", mv); end
    n_cmp++; if (pid !== 4'd3) begin n_err++; $display("FAIL basic_pid: got %0d want 3", pid); end
    n_cmp++; if (pos !== 16'd2) begin n_err++; $display("FAIL basic_pos: got %0d want 2", pos); end
    n_cmp++; if (cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL basic_cnt: got %0d want %0d", cnt, CNT_ON ? 1 : 0); end
    pop();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL basic_popped: got %b want 0", mv); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) feed(8'd5);
    step(); step();
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_cmp++; if (cnt !== (CNT_ON ? 16'd9 : 16'd0)) begin n_err++; $display("FAIL ovf_cnt: got %0d want %0d", cnt, CNT_ON ? 9 : 0); end
    step();
    n_cmp++; if (pos !== 16'd0 || pid !== 4'd3) begin n_err++; $display("FAIL ovf_hold: got pid %0d pos %0d want pid 3 pos 0", pid, pos); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mv !== 1'b1 || pos !== 16'(i)) begin
        n_err++; $display("FAIL ovf_entry%0d: got valid %b pos %0d want valid 1 pos %0d", i, mv, pos, i);
      end
      pop();
    end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", mv); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) feed(8'd5);
    step(); step();
    feed(8'd5);
    MATCH_READY = 1'b1;
    step();
    MATCH_READY = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mv !== 1'b1 || pos !== 16'(i + 1)) begin
        n_err++; $display("FAIL fullpop_entry%0d: got valid %b pos %0d want valid 1 pos %0d", i, mv, pos, i + 1);
      end
      pop();
    end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL fullpop_drained: got %b want 0", mv); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 20; k++) feed((k == 18) ? 8'd5 : 8'd0);
    n_cmp++; if (mv4 !== 1'b1 || pid4 !== 4'd3) begin n_err++; $display("FAIL wrap_valid: got valid %b pid %0d want 1 pid 3", mv4, pid4); end
    n_cmp++; if (pos4 !== 4'd1) begin n_err++; $display("FAIL wrap_pos4: got %0d want 1", pos4); end
    n_cmp++; if (pos !== 16'd17) begin n_err++; $display("FAIL wrap_pos16: got %0d want 17", pos); end
    pop();
    n_cmp++; if (mv4 !== 1'b0) begin n_err++; $display("FAIL wrap_popped: got %b want 0", mv4); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(8'd5); feed(8'd5); feed(8'd5);
    step(); step();
    n_cmp++; if (mv !== 1'b1) begin n_err++; $display("FAIL rstmid_queued: got %b want 1", mv); end
    feed(8'd5);
    RST = 1'b1; EN = 1'b1; NOW_STATE = 8'd5; MATCH_READY = 1'b1;
    step();
    RST = 1'b0; EN = 1'b0; MATCH_READY = 1'b0;
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", mv); end
    n_cmp++; if (pid !== 4'd0 || pos !== 16'd0) begin n_err++; $display("FAIL rstmid_head: got pid %0d pos %0d want 0 0", pid, pos); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", cnt); end
    step(); step();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL rstmid_inflight: got %b want 0", mv); end
    feed(8'd5);
    step();
    n_cmp++; if (mv !== 1'b1 || pid !== 4'd3 || pos !== 16'd0) begin n_err++; $display("FAIL rstmid_next: got valid %b pid %0d pos %0d want 1 3 0", mv, pid, pos); end
    pop();
  endtask

  task automatic test_same_cycle();
    do_reset();
    OUT_WE = 1'b1; OUT_WADDR = 8'd7; OUT_WDATA = 5'h16;
    EN = 1'b1; NOW_STATE = 8'd7;
    step();
    OUT_WE = 1'b0; EN = 1'b0;
    step(); step();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL same_old: got %b want 0", mv); end
    feed(8'd7);
    step();
    n_cmp++; if (mv !== 1'b1 || pid !== 4'd6 || pos !== 16'd1) begin n_err++; $display("FAIL same_new: got valid %b pid %0d pos %0d want 1 6 1", mv, pid, pos); end
    pop();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL same_popped: got %b want 0", mv); end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; NOW_STATE = '0; OUT_WE = 1'b0;
    OUT_WADDR = '0; OUT_WDATA = '0; MATCH_READY = 1'b0;
    for (int s = 0; s < 256; s++) write_tab(8'(s), 5'd0);
    step();
    test_reset();
    RST = 1'b0;
    test_basic();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_reporter.md
MATCH_REPORTER -- requirements
Module: match_reporter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, match FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter POS_W, default 16, width of the character-position counter and MATCH_POS.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port EN, input, 1, NOW_STATE valid; one scanned character per EN cycle.
REQ-006 SHALL have port NOW_STATE, input, 8, automaton state reached after the current character.
REQ-007 SHALL have port OUT_WE, input, 1, output-table write strobe.
REQ-008 SHALL have port OUT_WADDR, input, 8, output-table write address (state number).
REQ-009 SHALL have port OUT_WDATA, input, 5, table write data: bit4 accepting flag, bits3:0 pattern ID.
REQ-010 SHALL have port MATCH_VALID, output, 1, FIFO head valid.
REQ-011 SHALL have port MATCH_READY, input, 1, consumer accepts the head entry.
REQ-012 SHALL have port MATCH_PID, output, 4, pattern ID of the head entry.
REQ-013 SHALL have port MATCH_POS, output, POS_W, position of the last character of the match.
REQ-014 SHALL have port OVERFLOW, output, 1, sticky flag: a match was dropped.
REQ-015 SHALL have port MATCH_CNT, output, 16, number of detected matches.

Function
REQ-016 SHALL hold a 256x5 output table; entries power up to 0 and are not cleared by RST.
REQ-017 SHALL write the table in the cycle OUT_WE=1; a same-address read in that cycle returns the old data.
REQ-018 SHALL keep a POS_W-bit position counter: 0 after reset, +1 per EN cycle, wrapping from all-ones to 0.
REQ-019 SHALL tag each EN cycle with the pre-increment counter value, so the first character after reset has position 0.
REQ-020 SHALL be a two-stage pipeline: stage 1 registered table read plus position; stage 2 FIFO push when the flag is set.
REQ-021 SHALL make MATCH_VALID rise no earlier than 2 cycles after the EN cycle whose state is accepting, when the FIFO is empty.
REQ-022 SHALL pop the head entry on MATCH_VALID && MATCH_READY; MATCH_READY is ignored while MATCH_VALID=0.
REQ-023 SHALL hold MATCH_PID and MATCH_POS stable while MATCH_VALID=1 and MATCH_READY=0.
REQ-024 SHALL output matches in detection order; there is no back-pressure to EN.
REQ-025 SHALL, when FIFO full with no pop, drop the new match and set OVERFLOW until RST.
REQ-026 SHALL, when FIFO full with a pop in the same cycle, accept the push; no drop, no OVERFLOW.
REQ-027 SHALL, when FIFO empty, not pop in a push cycle; the pushed entry appears the next cycle.
REQ-028 SHALL increment MATCH_CNT on each detected match, dropped ones included, saturating at 0xFFFF.
REQ-029 SHALL ignore non-accepting states (bit4=0) apart from advancing the position counter.

Reset
REQ-030 SHALL, on RST, clear position counter, pipeline valids, FIFO pointers, OVERFLOW and MATCH_CNT; MATCH_VALID=0 next cycle; MATCH_PID=0; MATCH_POS=0.
REQ-031 SHALL, on RST mid-operation, discard in-flight and queued matches with no partial output; the table is retained.
REQ-032 SHALL take RST as priority over EN, OUT_WE pipeline effects and pops in the same cycle; the table write still occurs.

Configuration
REQ-033 SHALL compile the MATCH_CNT counter only when macro MATCH_REPORTER_CNT_EN is defined.
REQ-034 SHALL, without MATCH_REPORTER_CNT_EN, tie MATCH_CNT to 0; the port remains and all other behaviour is unchanged.

Verification
REQ-035 SHALL cover: load state 5 = {1,PID 3}, EN with states 0,0,5 -> one entry PID=3 POS=2, MATCH_VALID 2 cycles after the state-5 EN cycle.
REQ-036 SHALL cover: MATCH_READY=0, 9 consecutive accepting EN cycles at depth 8 -> 8 entries, positions 0..7, OVERFLOW=1, MATCH_CNT=9.
REQ-037 SHALL cover: FIFO full and MATCH_READY=1 in the push cycle -> no drop, OVERFLOW stays 0, entry count stays 8.
REQ-038 SHALL cover: POS_W=4, 20 EN cycles with a match on the 18th character -> MATCH_POS=1 (wrap).
REQ-039 SHALL cover: RST with 3 entries queued -> MATCH_VALID=0 the next cycle, MATCH_CNT=0, table retained, next match at POS=0.
REQ-040 SHALL cover: a write and an accepting EN to the same state in one cycle -> old entry used for that character.
